// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: state encodings and
// default geometry of the 16x1 mux stage.
package mux_scan_pkg;

    localparam int SEL_W_DEF  = 4;
    localparam int N_CH_DEF   = 16;
    localparam int SETTLE_DEF = 2;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_SETTLE = 2'd1;
    localparam logic [1:0] STATE_SAMPLE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = STATE_IDLE,
        S_SETTLE = STATE_SETTLE,
        S_SAMPLE = STATE_SAMPLE
    } scan_state_e;

endpackage

// File: rtl/scan_frame_reg.sv
// Output frame register: holds the last published frame, runs the
// valid/ready handshake and keeps the sticky overrun flag.
module scan_frame_reg
    import mux_scan_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_publish,
    input  logic [N_CH-1:0] i_pub_data,
    input  logic            i_clr_overrun,
    input  logic            i_frame_ready,
    output logic [N_CH-1:0] o_frame,
    output logic            o_frame_valid,
    output logic            o_overrun
);

    logic [N_CH-1:0] r_frame;
    logic            r_frame_valid;
    logic            r_overrun;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // valid falls after a transfer unless a new frame is published in the
    // same cycle; frame only changes while the slot is free or being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
            if (i_publish) begin
                if (!r_frame_valid || i_frame_ready) begin
                    r_frame       <= i_pub_data;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_frame_valid && i_frame_ready) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign o_frame       = r_frame;
    assign o_frame_valid = r_frame_valid;
    assign o_overrun     = r_overrun;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives the mux select through every channel, waits for it to settle,
// samples the mux output and packs one bit per channel into a frame.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SEL_W  = SEL_W_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_cont,
    output logic [SEL_W-1:0] si,
    input  logic             y,
    output logic [N_CH-1:0]  frame,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             busy,
    output logic             overrun,
    output logic [1:0]       dbg_state
);

    localparam int               CNT_W   = 4;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SETTLE - 1);

    scan_state_e      r_state;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [SEL_W-1:0] r_si;
    logic             r_busy;
    // The last channel's bit comes straight from y at publish time.
    logic [N_CH-2:0]  r_acc;

    logic             w_last_ch;
    logic             w_publish;
    logic             w_clr_overrun;
    logic [N_CH-1:0]  w_pub_data;

    assign w_last_ch     = (r_si == LAST_CH);
    assign w_publish     = (r_state == S_SAMPLE) && w_last_ch;
    assign w_clr_overrun = (r_state == S_IDLE) && start;
    assign w_pub_data    = {y, r_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_si         <= '0;
            r_busy       <= 1'b0;
            r_acc        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_si <= '0;
                    if (start) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + CNT_W'(1);
                    if (r_settle_cnt == CNT_END) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_settle_cnt <= '0;
                    if (!w_last_ch) begin
                        r_acc[r_si] <= y;
                        r_si        <= r_si + SEL_W'(1);
                        r_state     <= S_SETTLE;
                    end else begin
                        // mode_cont is only looked at here, so a mid-scan
                        // change lets the current frame finish.
                        r_si <= '0;
                        if (mode_cont) begin
                            r_state <= S_SETTLE;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_settle_cnt <= '0;
                    r_si         <= '0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    scan_frame_reg #(
        .N_CH (N_CH)
    ) u_frame_reg (
        .clk           (clk),
        .rst           (rst),
        .i_publish     (w_publish),
        .i_pub_data    (w_pub_data),
        .i_clr_overrun (w_clr_overrun),
        .i_frame_ready (frame_ready),
        .o_frame       (frame),
        .o_frame_valid (frame_valid),
        .o_overrun     (overrun)
    );

    assign si        = r_si;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer with a behavioural 16x1 mux (y = di[si]).
// Accepted frames are checked against an expected queue by a monitor.
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode_cont = 1'b0;
    logic        frame_ready = 1'b0;
    logic [3:0]  si;
    logic        y;
    logic [15:0] frame;
    logic        frame_valid;
    logic        busy;
    logic        overrun;
    logic [1:0]  dbg_state;
    logic [15:0] di = 16'h0000;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    always #5 clk = ~clk;

    assign y = di[si];

    mux_scan_sequencer #(
        .SEL_W  (4),
        .N_CH   (16),
        .SETTLE (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode_cont   (mode_cont),
        .si          (si),
        .y           (y),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transfer (valid && ready) must match the next expected frame.
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                err_cnt++;
                $display("FAIL unexpected_frame: got %0h, expected no frame at %0t", frame, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("frame_out", {16'h0, frame}, {16'h0, mon_exp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    // Leaves the bench at the start of cycle 1 (start sampled at cycle 0).
    task automatic start_scan();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Single-shot scan with ready held high, checking si each cycle.
    task automatic run_scan(input logic [15:0] pat, input bit pulse);
        di = pat;
        exp_q.push_back(pat);
        start_scan();
        for (int c = 1; c <= 48; c++) begin
            start = pulse && (c == 10 || c == 30);
            @(negedge clk);
            chk("si_step", {28'h0, si}, (c - 1) / 3);
            chk("busy_scan", {31'h0, busy}, 1);
            chk("valid_early", {31'h0, frame_valid}, 0);
            step();
        end
        start = 1'b0;
        @(negedge clk);
        chk("valid_at_49", {31'h0, frame_valid}, 1);
        chk("frame_at_49", {16'h0, frame}, {16'h0, pat});
        chk("busy_at_49", {31'h0, busy}, 0);
        chk("si_at_49", {28'h0, si}, 0);
        chk("state_at_49", {30'h0, dbg_state}, 0);
        step();
        @(negedge clk);
        chk("valid_after_accept", {31'h0, frame_valid}, 0);
        step();
    endtask

    initial begin
        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_si", {28'h0, si}, 0);
        chk("rst_frame", {16'h0, frame}, 0);
        chk("rst_valid", {31'h0, frame_valid}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_overrun", {31'h0, overrun}, 0);
        chk("rst_state", {30'h0, dbg_state}, 0);
        step();

        // Single-shot scan
        mode_cont = 1'b0;
        frame_ready = 1'b1;
        run_scan(16'hA5C3, 1'b0);

        // Continuous, consumer stalled: second frame dropped
        do_reset();
        mode_cont = 1'b1;
        frame_ready = 1'b0;
        di = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        start_scan();
        repeat (48) step();
        @(negedge clk);
        chk("ovr_first_valid", {31'h0, frame_valid}, 1);
        chk("ovr_first_frame", {16'h0, frame}, 16'hA5C3);
        chk("ovr_first_flag", {31'h0, overrun}, 0);
        step();
        di = 16'h1234;
        mode_cont = 1'b0;
        repeat (47) step();
        @(negedge clk);
        chk("ovr_frame_kept", {16'h0, frame}, 16'hA5C3);
        chk("ovr_valid_kept", {31'h0, frame_valid}, 1);
        chk("ovr_flag_set", {31'h0, overrun}, 1);
        chk("ovr_idle_busy", {31'h0, busy}, 0);
        step();
        frame_ready = 1'b1;
        step();
        @(negedge clk);
        chk("ovr_valid_fall", {31'h0, frame_valid}, 0);
        chk("ovr_sticky", {31'h0, overrun}, 1);
        step();
        exp_q.push_back(16'h1234);
        start_scan();
        @(negedge clk);
        chk("ovr_clr_on_start", {31'h0, overrun}, 0);
        step();
        repeat (47) step();
        @(negedge clk);
        chk("ovr_rescan_valid", {31'h0, frame_valid}, 1);
        repeat (2) step();

        // start pulses while busy are ignored
        do_reset();
        mode_cont = 1'b0;
        frame_ready = 1'b1;
        run_scan(16'h5A3C, 1'b1);

        // Reset mid-scan
        do_reset();
        di = 16'hC3A5;
        start_scan();
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_si", {28'h0, si}, 0);
        chk("mid_rst_busy", {31'h0, busy}, 0);
        chk("mid_rst_valid", {31'h0, frame_valid}, 0);
        chk("mid_rst_overrun", {31'h0, overrun}, 0);
        chk("mid_rst_state", {30'h0, dbg_state}, 0);
        step();
        di = 16'h0FF0;
        exp_q.push_back(16'h0FF0);
        start_scan();
        repeat (47) step();
        @(negedge clk);
        chk("mid_rst_valid_48", {31'h0, frame_valid}, 0);
        step();
        @(negedge clk);
        chk("mid_rst_valid_49", {31'h0, frame_valid}, 1);
        chk("mid_rst_frame_49", {16'h0, frame}, 16'h0FF0);
        repeat (2) step();

        // Ready pulsed in the last-channel SAMPLE cycle of scan 2
        do_reset();
        mode_cont = 1'b1;
        frame_ready = 1'b0;
        di = 16'h8001;
        exp_q.push_back(16'h8001);
        exp_q.push_back(16'h7FFE);
        start_scan();
        repeat (48) step();
        @(negedge clk);
        chk("pass_first_frame", {16'h0, frame}, 16'h8001);
        step();
        di = 16'h7FFE;
        mode_cont = 1'b0;
        repeat (46) step();
        frame_ready = 1'b1;
        @(negedge clk);
        chk("pass_last_si", {28'h0, si}, 15);
        chk("pass_last_state", {30'h0, dbg_state}, 2);
        step();
        frame_ready = 1'b0;
        @(negedge clk);
        chk("pass_valid_held", {31'h0, frame_valid}, 1);
        chk("pass_new_frame", {16'h0, frame}, 16'h7FFE);
        chk("pass_no_overrun", {31'h0, overrun}, 0);
        step();
        frame_ready = 1'b1;
        step();
        @(negedge clk);
        chk("pass_valid_fall", {31'h0, frame_valid}, 0);
        step();

        // mode_cont dropped mid-scan finishes the frame then idles
        do_reset();
        mode_cont = 1'b1;
        frame_ready = 1'b1;
        di = 16'hF00F;
        exp_q.push_back(16'hF00F);
        start_scan();
        repeat (24) step();
        mode_cont = 1'b0;
        repeat (24) step();
        @(negedge clk);
        chk("drop_valid_49", {31'h0, frame_valid}, 1);
        chk("drop_frame_49", {16'h0, frame}, 16'hF00F);
        chk("drop_state_49", {30'h0, dbg_state}, 0);
        chk("drop_busy_49", {31'h0, busy}, 0);
        chk("drop_si_49", {28'h0, si}, 0);
        repeat (3) step();
        @(negedge clk);
        chk("drop_still_idle", {30'h0, dbg_state}, 0);
        chk("drop_no_rescan", {31'h0, busy}, 0);
        chk("drop_valid_gone", {31'h0, frame_valid}, 0);

        step();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
